led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: runs LED light patterns (blink, chase, bounce) for a commanded
// number of cycles, stepping at a rate set by a clock prescaler and a per-command
// step length.
//
// Ports:
//   clk         single clock, all logic on posedge
//   reset_n     synchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   command accepted when high together with cmd_valid (IDLE only)
//   cmd_mode    00 OFF, 01 BLINK, 10 CHASE, 11 BOUNCE
//   cmd_steps   ticks per pattern step, 0 behaves as 1
//   cmd_repeat  pattern cycles to run, 0 runs until stopped
//   stop        abort a running pattern
//   brightness  (LED_SEQ_PWM_EN only) PWM duty in 1/16ths, 0 = dark
//   led         LED drive, 1 = on
//   busy        high while a pattern runs
//   done        one-cycle pulse at completion or abort
//
// Optional feature: define LED_SEQ_PWM_EN to add the brightness input and a
// free-running 4-bit PWM counter that gates every LED bit.

module led_sequencer #(
   parameter int unsigned CLK_DIV  = 25000000,
   parameter int unsigned NUM_LEDS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [7:0]          cmd_steps,
   input  logic [7:0]          cmd_repeat,
   input  logic                stop,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0]          brightness,
`endif
   output logic [NUM_LEDS-1:0] led,
   output logic                busy,
   output logic                done
);

   localparam int unsigned PresW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PosW  = $clog2(2 * NUM_LEDS);

   localparam logic [PresW-1:0] PresLast   = PresW'(CLK_DIV - 1);
   localparam logic [PosW-1:0]  BlinkLast  = PosW'(1);
   localparam logic [PosW-1:0]  ChaseLast  = PosW'(NUM_LEDS - 1);
   localparam logic [PosW-1:0]  BounceLast = PosW'(2 * NUM_LEDS - 3);

   localparam logic [1:0] ModeOff    = 2'b00;
   localparam logic [1:0] ModeBlink  = 2'b01;
   localparam logic [1:0] ModeChase  = 2'b10;
   localparam logic [1:0] ModeBounce = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [7:0]           steps_q, steps_d;
   logic [7:0]           rep_q, rep_d;
   logic [PresW-1:0]     presc_q, presc_d;
   logic [7:0]           step_cnt_q, step_cnt_d;
   logic [PosW-1:0]      pos_q, pos_d;
   logic [7:0]           cyc_q, cyc_d;
   logic [NUM_LEDS-1:0]  led_q, led_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 cmd_ready_q, cmd_ready_d;

   logic                 tick;
   logic [7:0]           step_last;
   logic [PosW-1:0]      cycle_last;
   logic [7:0]           cyc_inc;

   // Pattern value for a given position within the cycle. The position fully
   // determines the LEDs, so no separate shift/direction state is needed.
   function automatic logic [NUM_LEDS-1:0] pattern_at(input logic [1:0]      mode,
                                                      input logic [PosW-1:0] pos);
      logic [NUM_LEDS-1:0] p;
      int unsigned         idx;
      p   = '0;
      idx = 32'(pos);
      case (mode)
         ModeBlink: p = (pos == '0) ? '1 : '0;
         ModeChase: begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) p[i] = (i == idx);
         end
         ModeBounce: begin
            // Positions past the top bit walk back down: N -> N-2, ..., 2N-3 -> 1.
            if (idx >= NUM_LEDS) idx = 2 * NUM_LEDS - 2 - idx;
            for (int unsigned i = 0; i < NUM_LEDS; i++) p[i] = (i == idx);
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   always_comb begin
      case (mode_q)
         ModeBlink:  cycle_last = BlinkLast;
         ModeChase:  cycle_last = ChaseLast;
         ModeBounce: cycle_last = BounceLast;
         default:    cycle_last = BlinkLast;
      endcase
   end

   assign tick      = (state_q == StRun) && (presc_q == PresLast);
   assign step_last = (steps_q == 8'd0) ? 8'd0 : (steps_q - 8'd1);
   assign cyc_inc   = cyc_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      steps_d    = steps_q;
      rep_d      = rep_q;
      presc_d    = presc_q;
      step_cnt_d = step_cnt_q;
      pos_d      = pos_q;
      cyc_d      = cyc_q;
      led_d      = led_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               mode_d     = cmd_mode;
               steps_d    = cmd_steps;
               rep_d      = cmd_repeat;
               presc_d    = '0;
               step_cnt_d = '0;
               pos_d      = '0;
               cyc_d      = '0;
               led_d      = pattern_at(cmd_mode, '0);
               state_d    = (cmd_mode == ModeOff) ? StDone : StRun;
            end
         end

         StRun: begin
            // stop wins over any step advance on the same edge.
            if (stop) begin
               state_d = StDone;
            end else begin
               presc_d = tick ? '0 : (presc_q + PresW'(1));
               if (tick) begin
                  if (step_cnt_q == step_last) begin
                     step_cnt_d = '0;
                     if (pos_q == cycle_last) begin
                        pos_d = '0;
                        cyc_d = cyc_inc;
                        if ((rep_q != 8'd0) && (cyc_inc == rep_q)) state_d = StDone;
                     end else begin
                        pos_d = pos_q + PosW'(1);
                     end
                     led_d = pattern_at(mode_q, pos_d);
                  end else begin
                     step_cnt_d = step_cnt_q + 8'd1;
                  end
               end
            end
         end

         StDone: state_d = StIdle;

         default: state_d = StIdle;
      endcase

      // Outputs are registered and follow the state being entered.
      cmd_ready_d = (state_d == StIdle);
      busy_d      = (state_d == StRun);
      done_d      = (state_d == StDone);
      if (state_d != StRun) led_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         mode_q      <= ModeOff;
         steps_q     <= '0;
         rep_q       <= '0;
         presc_q     <= '0;
         step_cnt_q  <= '0;
         pos_q       <= '0;
         cyc_q       <= '0;
         led_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         steps_q     <= steps_d;
         rep_q       <= rep_d;
         presc_q     <= presc_d;
         step_cnt_q  <= step_cnt_d;
         pos_q       <= pos_d;
         cyc_q       <= cyc_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef LED_SEQ_PWM_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;

   assign pwm_cnt_d = pwm_cnt_q + 4'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) pwm_cnt_q <= 4'd0;
      else          pwm_cnt_q <= pwm_cnt_d;
   end

   assign led = led_q & {NUM_LEDS{pwm_cnt_q < brightness}};
`else
   assign led = led_q;
`endif

endmodule
